// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator controller and its cab/shaft/door plant model.
// Command and sensor codes plus fault-bit positions live here so both sides agree.
package elevator_pkg;

  localparam logic [1:0] ENG_STOP    = 2'b00;
  localparam logic [1:0] ENG_UP      = 2'b01;
  localparam logic [1:0] ENG_DOWN    = 2'b10;
  localparam logic [1:0] ENG_ILLEGAL = 2'b11;

  localparam logic [1:0] DOOR_HOLD    = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSE   = 2'b10;
  localparam logic [1:0] DOOR_ILLEGAL = 2'b11;

  localparam logic [1:0] SDOOR_CLOSED = 2'b10;
  localparam logic [1:0] SDOOR_OPEN   = 2'b01;
  localparam logic [1:0] SDOOR_MOVING = 2'b00;

  localparam int FAULT_INTERLOCK  = 0;
  localparam int FAULT_OVERTRAVEL = 1;
  localparam int FAULT_ILLEGAL    = 2;

  // The 11 encoding of either command bus behaves as "do nothing" for that cycle.
  function automatic logic [1:0] sanitize_cmd(input logic [1:0] cmd);
    return (cmd == 2'b11) ? 2'b00 : cmd;
  endfunction

endpackage

// File: rtl/bounded_updown_counter.sv
// Saturating up/down counter over [0, MAX] with registered end-of-range flags.
// The flags are computed from the next value so they stay aligned with the count itself.
module bounded_updown_counter #(
  parameter int MAX = 10,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         hold,
  output logic [W-1:0] value,
  output logic         at_min,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_q, value_d;
  logic         at_min_q, at_min_d;
  logic         at_max_q, at_max_d;

  always_comb begin
    value_d = value_q;
    if (!hold) begin
      if (inc && !dec && (value_q != MAX_V)) begin
        value_d = value_q + 1'b1;
      end else if (dec && !inc && (value_q != '0)) begin
        value_d = value_q - 1'b1;
      end
    end
    at_min_d = (value_d == '0);
    at_max_d = (value_d == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q  <= '0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign value  = value_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;

endmodule

// File: rtl/elevator_plant.sv
// Cab/shaft/door plant: turns engine and door commands into cab motion, door travel,
// arrival pulses and door sensors, while enforcing interlocks and latching misuse faults.
module elevator_plant
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 20,
  parameter int DOOR_CYCLES   = 10,
  parameter int START_FLOOR   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         engine,
  input  logic [1:0]         door,
  output logic               sensor_up,
  output logic               sensor_down,
  output logic [1:0]         sensor_door,
  output logic [FLOOR_W-1:0] cab_floor,
  output logic               at_floor,
  output logic [2:0]         fault
);

  localparam int SUB_W  = $clog2(TRAVEL_CYCLES);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);

  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(TRAVEL_CYCLES - 1);
  localparam logic [SUB_W-1:0]   SUB_ONE   = SUB_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] RST_FLOOR = FLOOR_W'(START_FLOOR);

  logic [FLOOR_W-1:0] cab_floor_q, cab_floor_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               at_floor_q, at_floor_d;
  logic               sensor_up_q, sensor_up_d;
  logic               sensor_down_q, sensor_down_d;
  logic [2:0]         fault_q, fault_d;

  logic [1:0]        eng_cmd, door_cmd;
  logic              illegal, eng_req, door_req;
  logic              door_closed, overtravel, door_ok, move_ok, interlock;
  logic              door_inc, door_dec;
  logic [DOOR_W-1:0] door_pos;
  logic              door_at_min, door_at_max;

  // Command qualification: a door move and an engine move in the same cycle cancel each other.
  always_comb begin
    eng_cmd     = sanitize_cmd(engine);
    door_cmd    = sanitize_cmd(door);
    illegal     = (engine == ENG_ILLEGAL) || (door == DOOR_ILLEGAL);
    eng_req     = (eng_cmd != ENG_STOP);
    door_req    = (door_cmd != DOOR_HOLD);
    door_closed = (door_pos == '0);
    overtravel  = at_floor_q &&
                  (((eng_cmd == ENG_UP) && (cab_floor_q == TOP_FLOOR)) ||
                   ((eng_cmd == ENG_DOWN) && (cab_floor_q == '0)));
    door_ok     = door_req && at_floor_q && !eng_req;
    move_ok     = eng_req && door_closed && !door_req && !overtravel;
    interlock   = (eng_req && !door_closed) || (door_req && !door_ok);
    door_inc    = door_ok && (door_cmd == DOOR_OPEN);
    door_dec    = door_ok && (door_cmd == DOOR_CLOSE);
  end

  // Going down from a floor, the cab is immediately "below" it, so the floor index drops first.
  always_comb begin
    cab_floor_d   = cab_floor_q;
    sub_d         = sub_q;
    sensor_up_d   = 1'b0;
    sensor_down_d = 1'b0;
    if (move_ok && (eng_cmd == ENG_UP)) begin
      if (sub_q == SUB_LAST) begin
        cab_floor_d = cab_floor_q + 1'b1;
        sub_d       = '0;
        sensor_up_d = 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end else if (move_ok && (eng_cmd == ENG_DOWN)) begin
      if (sub_q == '0) begin
        cab_floor_d = cab_floor_q - 1'b1;
        sub_d       = SUB_LAST;
      end else begin
        sub_d = sub_q - 1'b1;
        if (sub_q == SUB_ONE) begin
          sensor_down_d = 1'b1;
        end
      end
    end
    at_floor_d = (sub_d == '0);
    fault_d    = fault_q;
    fault_d[FAULT_INTERLOCK]  = fault_q[FAULT_INTERLOCK] | interlock;
    fault_d[FAULT_OVERTRAVEL] = fault_q[FAULT_OVERTRAVEL] | overtravel;
    fault_d[FAULT_ILLEGAL]    = fault_q[FAULT_ILLEGAL] | illegal;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cab_floor_q   <= RST_FLOOR;
      sub_q         <= '0;
      at_floor_q    <= 1'b1;
      sensor_up_q   <= 1'b0;
      sensor_down_q <= 1'b0;
      fault_q       <= '0;
    end else begin
      cab_floor_q   <= cab_floor_d;
      sub_q         <= sub_d;
      at_floor_q    <= at_floor_d;
      sensor_up_q   <= sensor_up_d;
      sensor_down_q <= sensor_down_d;
      fault_q       <= fault_d;
    end
  end

  bounded_updown_counter #(
    .MAX (DOOR_CYCLES),
    .W   (DOOR_W)
  ) u_door (
    .clk    (clk),
    .reset  (reset),
    .inc    (door_inc),
    .dec    (door_dec),
    .hold   (!door_ok),
    .value  (door_pos),
    .at_min (door_at_min),
    .at_max (door_at_max)
  );

  assign sensor_up   = sensor_up_q;
  assign sensor_down = sensor_down_q;
  assign sensor_door = {door_at_min, door_at_max};
  assign cab_floor   = cab_floor_q;
  assign at_floor    = at_floor_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_plant.sv
// Directed self-checking bench for elevator_plant with the default 8-floor, 20/10-cycle timing.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_elevator_plant;

  logic       clk;
  logic       reset;
  logic [1:0] engine;
  logic [1:0] door;
  logic       sensor_up;
  logic       sensor_down;
  logic [1:0] sensor_door;
  logic [2:0] cab_floor;
  logic       at_floor;
  logic [2:0] fault;

  int checks;
  int errors;
  int pulses;

  elevator_plant dut (
    .clk         (clk),
    .reset       (reset),
    .engine      (engine),
    .door        (door),
    .sensor_up   (sensor_up),
    .sensor_down (sensor_down),
    .sensor_door (sensor_door),
    .cab_floor   (cab_floor),
    .at_floor    (at_floor),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] eng, input logic [1:0] dr, input int n);
    engine = eng;
    door   = dr;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    engine = 2'b00;
    door   = 2'b00;
    tick(2);

    // Reset state
    checkOutput("rst_floor", 8'(cab_floor), 8'd0);
    checkOutput("rst_at_floor", 8'(at_floor), 8'd1);
    checkOutput("rst_sdoor", 8'(sensor_door), 8'b10);
    checkOutput("rst_up", 8'(sensor_up), 8'd0);
    checkOutput("rst_down", 8'(sensor_down), 8'd0);
    checkOutput("rst_fault", 8'(fault), 8'd0);
    reset = 1'b1;

    // 1: continuous up drive, one pulse per floor
    $display("[TB] step 1: drive up three floors");
    engine = 2'b01;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      checkOutput("t1_up_pulse", 8'(sensor_up), (i % 20 == 0) ? 8'd1 : 8'd0);
    end
    checkOutput("t1_floor", 8'(cab_floor), 8'd3);
    checkOutput("t1_at_floor", 8'(at_floor), 8'd1);
    checkOutput("t1_down", 8'(sensor_down), 8'd0);

    // 2: open then close the door at floor 3
    $display("[TB] step 2: door open/close");
    engine = 2'b00;
    door   = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checkOutput("t2_open", 8'(sensor_door), (i == 10) ? 8'b01 : 8'b00);
    end
    door = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checkOutput("t2_close", 8'(sensor_door), (i == 10) ? 8'b10 : 8'b00);
    end
    checkOutput("t2_fault", 8'(fault), 8'd0);

    // 3: engine with door open is refused
    $display("[TB] step 3: interlock");
    applyStimulus(2'b00, 2'b01, 10);
    checkOutput("t3_open", 8'(sensor_door), 8'b01);
    applyStimulus(2'b01, 2'b00, 1);
    checkOutput("t3_fault", 8'(fault), 8'b001);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      pulses += int'(sensor_up) + int'(sensor_down);
    end
    checkOutput("t3_pulses", 8'(pulses), 8'd0);
    checkOutput("t3_floor", 8'(cab_floor), 8'd3);
    checkOutput("t3_at_floor", 8'(at_floor), 8'd1);

    // 4: partial segment and reversal back to floor 0
    $display("[TB] step 4: reversal");
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 1);
    reset = 1'b1;
    checkOutput("t4_rst_sdoor", 8'(sensor_door), 8'b10);
    applyStimulus(2'b01, 2'b00, 8);
    checkOutput("t4_mid_at_floor", 8'(at_floor), 8'd0);
    checkOutput("t4_mid_floor", 8'(cab_floor), 8'd0);
    engine = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      checkOutput("t4_down_pulse", 8'(sensor_down), (i == 8) ? 8'd1 : 8'd0);
      checkOutput("t4_no_up", 8'(sensor_up), 8'd0);
    end
    checkOutput("t4_floor", 8'(cab_floor), 8'd0);
    checkOutput("t4_at_floor", 8'(at_floor), 8'd1);
    checkOutput("t4_fault", 8'(fault), 8'd0);

    // 5: run to the top, then overtravel and an illegal command
    $display("[TB] step 5: overtravel and illegal");
    engine = 2'b01;
    pulses = 0;
    for (int i = 0; i < 140; i++) begin
      tick(1);
      pulses += int'(sensor_up);
    end
    checkOutput("t5_pulses", 8'(pulses), 8'd7);
    checkOutput("t5_floor", 8'(cab_floor), 8'd7);
    checkOutput("t5_fault0", 8'(fault), 8'd0);
    applyStimulus(2'b01, 2'b00, 1);
    checkOutput("t5_overtravel", 8'(fault), 8'b010);
    checkOutput("t5_floor_held", 8'(cab_floor), 8'd7);
    checkOutput("t5_at_floor", 8'(at_floor), 8'd1);
    applyStimulus(2'b11, 2'b00, 1);
    checkOutput("t5_illegal", 8'(fault), 8'b110);
    checkOutput("t5_floor_ill", 8'(cab_floor), 8'd7);

    // 6: reset abandons motion mid-segment
    $display("[TB] step 6: reset mid-segment");
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 1);
    reset = 1'b1;
    applyStimulus(2'b01, 2'b00, 49);
    checkOutput("t6_pre_floor", 8'(cab_floor), 8'd2);
    checkOutput("t6_pre_at_floor", 8'(at_floor), 8'd0);
    reset = 1'b0;
    tick(1);
    checkOutput("t6_floor", 8'(cab_floor), 8'd0);
    checkOutput("t6_at_floor", 8'(at_floor), 8'd1);
    checkOutput("t6_sdoor", 8'(sensor_door), 8'b10);
    checkOutput("t6_fault", 8'(fault), 8'd0);
    reset  = 1'b1;
    engine = 2'b00;
    tick(2);
    checkOutput("t6_stay", 8'(cab_floor), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
